// File: rtl/zbt_reader.sv
// zbt_reader: streams 8-bit pixels out of 32-bit ZBT words, prefetching one word ahead along each line.
// Define ZBT_READER_BLANK_HOLD_EN to hold the last active pixel during blanking instead of driving 0.
module zbt_reader #(
    parameter int H_ACTIVE = 1024,
    parameter int H_TOTAL  = 1344,
    parameter int V_ACTIVE = 768,
    parameter int V_TOTAL  = 806
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [35:0] zbtr_read_data,
    output logic [18:0] zbtr_read_addr,
    output logic [7:0]  pixel,
    output logic        pixel_valid,
    output logic        frame_start
);
    typedef enum logic {WAIT_FRAME, RUN} state_t;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_PF   = 11'(H_ACTIVE - 4);
    localparam logic [10:0] H_LINE = 11'(H_TOTAL - 4);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    state_t      state_q, state_d;
    logic [18:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  pixel_q, pixel_d;
    logic        valid_q, valid_d;
    logic        start_q, start_d;
    logic        frame_pf, active;
    logic [9:0]  ynext;
    logic [7:0]  byte_sel, blank_pix;
    logic        unused_tag;

    assign unused_tag = ^zbtr_read_data[35:32];

    always_comb begin
        frame_pf  = hcount == H_LINE && vcount == V_LAST;
        active    = hcount < H_ACT && vcount < V_ACT;
        ynext     = vcount == V_LAST ? 10'd0 : vcount + 10'd1;
        // column 0 of a word sits in the most significant byte
        byte_sel  = 8'(word_q >> {~hcount[1:0], 3'b000});
`ifdef ZBT_READER_BLANK_HOLD_EN
        blank_pix = pixel_q;
`else
        blank_pix = 8'd0;
`endif
        addr_d    = hcount == H_LINE ? {1'b0, ynext, 8'd0}
                  : (hcount[1:0] == 2'd0 && hcount < H_PF) ? {1'b0, vcount, hcount[9:2] + 8'd1}
                  : addr_q;
        word_d    = hcount[1:0] == 2'd3 ? zbtr_read_data[31:0] : word_q;
        state_d   = frame_pf ? RUN : state_q;
        start_d   = frame_pf;
        valid_d   = state_q == RUN && active;
        pixel_d   = state_q != RUN ? 8'd0 : active ? byte_sel : blank_pix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_FRAME;
            addr_q  <= '0;
            word_q  <= '0;
            pixel_q <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            start_q <= start_d;
        end
    end

    assign zbtr_read_addr = addr_q;
    assign pixel          = pixel_q;
    assign pixel_valid    = valid_q;
    assign frame_start    = start_q;
endmodule

// File: tb/tb_zbt_reader.sv
// tb_zbt_reader: directed checks of zbt_reader against a 2-cycle-latency ZBT model.
module tb_zbt_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [35:0] zbtr_read_data;
    logic [18:0] zbtr_read_addr;
    logic [7:0]  pixel;
    logic        pixel_valid;
    logic        frame_start;
    logic [18:0] d1, d2;
    int          mode;
    int          errors = 0;
    int          checks = 0;

    zbt_reader dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .zbtr_read_data(zbtr_read_data), .zbtr_read_addr(zbtr_read_addr),
        .pixel(pixel), .pixel_valid(pixel_valid), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // data seen two cycles after the address changes
    always @(posedge clk) begin
        d1 <= zbtr_read_addr;
        d2 <= d1;
    end

    always_comb begin
        zbtr_read_data = 36'h0_1234565A;
        if (mode == 0) zbtr_read_data = {4'hF, 13'd0, d2};
        else if (mode == 1) zbtr_read_data = (d2 == 19'd0) ? 36'hF_AABBCCDD : 36'hF_00000000;
    end

    task automatic step(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(0, 0);
        step(0, 0);
        checks++; if (zbtr_read_addr !== 19'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", zbtr_read_addr); end
        checks++; if (pixel !== 8'd0) begin errors++; $display("FAIL reset_pixel got=%h exp=0", pixel); end
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pixel_valid); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        reset = 1'b0;
        step(0, 0);
        checks++; if (pixel_valid !== 1'b0 || pixel !== 8'd0) begin errors++; $display("FAIL wait_out got=%b/%h exp=0/00", pixel_valid, pixel); end
        checks++; if (zbtr_read_addr !== 19'd1) begin errors++; $display("FAIL wait_prefetch got=%h exp=00001", zbtr_read_addr); end
    endtask

    task automatic test_frame_entry;
        step(1340, 805);
        checks++; if (zbtr_read_addr !== 19'd0) begin errors++; $display("FAIL entry_addr got=%h exp=0", zbtr_read_addr); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL entry_fs got=%b exp=1", frame_start); end
        step(1341, 805);
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL entry_fs_pulse got=%b exp=0", frame_start); end
    endtask

    task automatic test_stream;
        logic [18:0] exp_addr;
        logic [31:0] w;
        logic [7:0]  exp_pix;
        logic [10:0] hh;
        mode = 0;
        for (int h = 1340; h < 1344; h++) step(h, 4);
        exp_addr = {1'b0, 10'd5, 8'd0};
        checks++; if (zbtr_read_addr !== exp_addr) begin errors++; $display("FAIL line_pf got=%h exp=%h", zbtr_read_addr, exp_addr); end
        for (int h = 0; h < 1024; h++) begin
            hh = 11'(h);
            step(h, 5);
            if (hh[1:0] == 2'd0 && h < 1020) exp_addr = {1'b0, 10'd5, hh[9:2] + 8'd1};
            w = {13'd0, 1'b0, 10'd5, hh[9:2]};
            exp_pix = 8'(w >> (8 * (3 - int'(hh[1:0]))));
            checks++; if (zbtr_read_addr !== exp_addr) begin errors++; $display("FAIL stream_addr h=%0d got=%h exp=%h", h, zbtr_read_addr, exp_addr); end
            checks++; if (pixel !== exp_pix || pixel_valid !== 1'b1) begin errors++; $display("FAIL stream_pix h=%0d got=%h/%b exp=%h/1", h, pixel, pixel_valid, exp_pix); end
            checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL stream_fs h=%0d got=%b exp=0", h, frame_start); end
        end
    endtask

    task automatic test_bits;
        logic [7:0] exp_b[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        mode = 1;
        step(1340, 805);
        checks++; if (zbtr_read_addr !== 19'd0) begin errors++; $display("FAIL wrap_addr got=%h exp=0", zbtr_read_addr); end
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL rerun_fs got=%b exp=1", frame_start); end
        for (int h = 1341; h < 1344; h++) step(h, 805);
        for (int h = 0; h < 4; h++) begin
            step(h, 0);
            checks++; if (pixel !== exp_b[h] || pixel_valid !== 1'b1) begin errors++; $display("FAIL bytes h=%0d got=%h/%b exp=%h/1", h, pixel, pixel_valid, exp_b[h]); end
        end
    endtask

    task automatic test_boundary;
        step(1340, 100);
        checks++; if (zbtr_read_addr !== {1'b0, 10'd101, 8'd0}) begin errors++; $display("FAIL next_line got=%h exp=%h", zbtr_read_addr, {1'b0, 10'd101, 8'd0}); end
        step(0, 767);
        checks++; if (pixel_valid !== 1'b1) begin errors++; $display("FAIL last_line got=%b exp=1", pixel_valid); end
        step(1023, 767);
        checks++; if (pixel_valid !== 1'b1) begin errors++; $display("FAIL last_col got=%b exp=1", pixel_valid); end
        step(1024, 767);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL hblank got=%b exp=0", pixel_valid); end
        step(0, 768);
        checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL vblank got=%b exp=0", pixel_valid); end
    endtask

    task automatic test_blank;
        logic [7:0] exp_blank;
`ifdef ZBT_READER_BLANK_HOLD_EN
        exp_blank = 8'h5A;
`else
        exp_blank = 8'h00;
`endif
        mode = 2;
        for (int h = 1019; h < 1024; h++) step(h, 10);
        checks++; if (pixel !== 8'h5A || pixel_valid !== 1'b1) begin errors++; $display("FAIL pre_blank got=%h/%b exp=5a/1", pixel, pixel_valid); end
        step(1024, 10);
        checks++; if (pixel !== exp_blank || pixel_valid !== 1'b0) begin errors++; $display("FAIL blank got=%h/%b exp=%h/0", pixel, pixel_valid, exp_blank); end
        step(1100, 10);
        checks++; if (pixel !== exp_blank) begin errors++; $display("FAIL blank_hold got=%h exp=%h", pixel, exp_blank); end
    endtask

    task automatic test_reset_mid;
        mode = 1;
        step(500, 10);
        checks++; if (pixel_valid !== 1'b1) begin errors++; $display("FAIL pre_reset got=%b exp=1", pixel_valid); end
        reset = 1'b1;
        step(501, 10);
        reset = 1'b0;
        checks++; if (pixel_valid !== 1'b0 || zbtr_read_addr !== 19'd0 || pixel !== 8'd0) begin errors++; $display("FAIL mid_reset got=%b/%h/%h exp=0/0/0", pixel_valid, zbtr_read_addr, pixel); end
        for (int h = 502; h < 510; h++) begin
            step(h, 10);
            checks++; if (pixel_valid !== 1'b0) begin errors++; $display("FAIL post_reset h=%0d got=%b exp=0", h, pixel_valid); end
        end
        step(1340, 805);
        checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reentry_fs got=%b exp=1", frame_start); end
        for (int h = 1341; h < 1344; h++) step(h, 805);
        step(0, 0);
        checks++; if (pixel_valid !== 1'b1 || pixel !== 8'hAA) begin errors++; $display("FAIL reentry_pix got=%h/%b exp=aa/1", pixel, pixel_valid); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        mode = 0;
        reset = 1'b1;
        hcount = '0;
        vcount = '0;
        test_reset;
        test_frame_entry;
        test_stream;
        test_bits;
        test_boundary;
        test_blank;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/zbt_reader.md
ZBT_READER -- requirements
Module: zbt_reader

Interface
REQ-001 Parameter H_ACTIVE, default 1024: active pixels per line.
REQ-002 Parameter H_TOTAL, default 1344: hcount period; SHALL be a multiple of 4.
REQ-003 Parameter V_ACTIVE, default 768: active lines per frame.
REQ-004 Parameter V_TOTAL, default 806: vcount period.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 hcount  input  11  display column counter, 0..H_TOTAL-1.
REQ-008 vcount  input  10  display line counter, 0..V_TOTAL-1.
REQ-009 zbtr_read_data  input  36  ZBT read data, valid 2 cycles after zbtr_read_addr changes.
REQ-010 zbtr_read_addr  output  19  registered ZBT read address, {1'b0, y[9:0], word[7:0]}.
REQ-011 pixel  output  8  registered 8-bit pixel for the hcount/vcount of the previous cycle.
REQ-012 pixel_valid  output  1  high when pixel belongs to the active region and state is RUN.
REQ-013 frame_start  output  1  one-cycle pulse on entry to each RUN frame.

Function
REQ-014 Word format: bits [35:32] ignored; column x uses byte [31-8*x[1:0] -: 8], i.e. x[1:0]=0 -> [31:24], 3 -> [7:0].
REQ-015 Word address for column x on line y SHALL be {1'b0, y, x[9:2]}.
REQ-016 In-line prefetch: when hcount[1:0]==0 and hcount < H_ACTIVE-4, next zbtr_read_addr = {1'b0, vcount, hcount[9:2]+1}.
REQ-017 Line prefetch: when hcount==H_TOTAL-4, next zbtr_read_addr = {1'b0, ynext, 8'd0}; ynext = vcount+1, wrapping to 0 when vcount==V_TOTAL-1.
REQ-018 Otherwise zbtr_read_addr SHALL hold.
REQ-019 Word buffer: 32-bit register loaded from zbtr_read_data[31:0] at each edge where hcount[1:0]==3; holds otherwise.
REQ-020 Latency: pixel/pixel_valid for input (hcount,vcount) appear exactly 1 cycle later; pixel = byte REQ-014 of word buffer selected by hcount[1:0].
REQ-021 Active region: hcount < H_ACTIVE and vcount < V_ACTIVE; outside it pixel_valid=0.
REQ-022 State machine, two states: WAIT_FRAME, RUN.
REQ-023 WAIT_FRAME -> RUN at edge where hcount==H_TOTAL-4 and vcount==V_TOTAL-1 (frame prefetch issued); frame_start pulses the following cycle.
REQ-024 RUN stays RUN; frame_start pulses each time the REQ-023 condition recurs.
REQ-025 In WAIT_FRAME: pixel_valid=0, pixel=0; prefetch addressing (REQ-016..018) still runs.
REQ-026 hcount/vcount discontinuity (jump) SHALL not be detected; addressing follows inputs each cycle.

Reset
REQ-027 On reset: state WAIT_FRAME, zbtr_read_addr=0, word buffer=0, pixel=0, pixel_valid=0, frame_start=0.
REQ-028 Reset asserted mid-line SHALL take effect at the next edge; the next RUN entry requires a fresh REQ-023 condition.

Configuration
REQ-029 Macro ZBT_READER_BLANK_HOLD_EN defined: outside active region in RUN, pixel holds its last active value.
REQ-030 Macro undefined: outside active region pixel = 0; pixel_valid identical in both builds.

Verification
REQ-031 Reset then hcount=H_TOTAL-4, vcount=V_TOTAL-1 -> next addr 19'h0, state RUN, frame_start=1 one cycle after.
REQ-032 RAM model returns word=address, lat 2; vcount=5, hcount 0..1023 -> addr steps {5,1},{5,2}..{5,255}; pixel at column x equals byte x[1:0] of word {5,x[9:2]}.
REQ-033 Data 36'hF_AABBCCDD for word 0, line 0 -> pixels AA,BB,CC,DD at hcount 0..3, pixel_valid=1; bits [35:32] never visible.
REQ-034 vcount=805, hcount=1340 -> next addr {0,10'd0,8'd0}; vcount=767 last active line, vcount=768 -> pixel_valid=0.
REQ-035 hcount=1024 after pixel 8'h5A: macro defined -> pixel=5A, undefined -> pixel=0; pixel_valid=0 both.
REQ-036 Assert reset at hcount=500 in RUN -> next cycle pixel_valid=0, addr=0; no valid pixels until REQ-023 condition reached.
